// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer and the surrounding pipeline: EX branch
// resolution, ID jump decode, hazard/imem control in; fetch PC and flushes out.
interface pc_sequencer_if #(
  parameter int DATA_BITS = 32
);
  // control into the sequencer
  logic                 pcsel;
  logic [DATA_BITS-1:0] branch_target;
  logic                 jmp;
  logic [DATA_BITS-1:0] jmp_target;
  logic                 stall;
  logic                 imem_ready;
  logic                 halt;

  // fetch address, flushes and status out of the sequencer
  logic [DATA_BITS-1:0] pc_out;
  logic [DATA_BITS-1:0] pc_plus4;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 redirect_pending;
  logic                 halted;
  logic [31:0]          redirect_count;

  // pipeline side: drives control, observes PC/flushes
  modport master (
    output pcsel, branch_target, jmp, jmp_target, stall, imem_ready, halt,
    input  pc_out, pc_plus4, flush_ifid, flush_idex, redirect_pending,
           halted, redirect_count
  );

  // sequencer side
  modport slave (
    input  pcsel, branch_target, jmp, jmp_target, stall, imem_ready, halt,
    output pc_out, pc_plus4, flush_ifid, flush_idex, redirect_pending,
           halted, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, turns EX branches and ID jumps
// into redirects with IF/ID and ID/EX flushes, parks a redirect while imem
// back-pressures, and freezes on halt until reset.
module pc_sequencer #(
  parameter int                   DATA_BITS = 32,
  parameter logic [DATA_BITS-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave sq
);

  typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

  localparam logic [DATA_BITS-1:0] FOUR = DATA_BITS'(4);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] pc, pc_n;
  logic [DATA_BITS-1:0] pend, pend_n;
  logic [31:0]          cnt;
  logic                 cnt_inc;
  logic                 fl_ifid, fl_idex;

  // state, PC, parked target and redirect counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pend  <= pend_n;
      if (cnt_inc) cnt <= cnt + 32'd1;
    end
  end

  // next state, next PC and flushes; EX branch outranks ID jump and stall
  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    cnt_inc = 1'b0;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    unique case (state)
      RUN: begin
        if (sq.halt) begin
          state_n = HALT;
        end else if (sq.pcsel) begin
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
          if (sq.imem_ready) begin
            pc_n    = sq.branch_target;
            cnt_inc = 1'b1;
          end else begin
            pend_n  = sq.branch_target;
            state_n = HOLD;
          end
        end else if (sq.jmp && !sq.stall) begin
          fl_ifid = 1'b1;
          if (sq.imem_ready) begin
            pc_n    = sq.jmp_target;
            cnt_inc = 1'b1;
          end else begin
            pend_n  = sq.jmp_target;
            state_n = HOLD;
          end
        end else if (!sq.stall && sq.imem_ready) begin
          pc_n = pc + FOUR;
        end
      end
      HOLD: begin
        // keep squashing whatever IF would otherwise hand to ID
        fl_ifid = 1'b1;
        if (sq.halt) begin
          state_n = HALT;
        end else begin
          // a branch resolving now is older in program order than the parked
          // jump, so its target wins and the ID/EX slot is squashed
          if (sq.pcsel) begin
            pend_n  = sq.branch_target;
            fl_idex = 1'b1;
          end
          if (sq.imem_ready) begin
            pc_n    = sq.pcsel ? sq.branch_target : pend;
            cnt_inc = 1'b1;
            state_n = RUN;
          end
        end
      end
      HALT: begin
        // frozen; only reset leaves
      end
      default: state_n = RUN;
    endcase
  end

  // outputs; flushes are forced low while reset is applied
  assign sq.pc_out           = pc;
  assign sq.pc_plus4         = pc + FOUR;
  assign sq.flush_ifid       = fl_ifid & ~rst;
  assign sq.flush_idex       = fl_idex & ~rst;
  assign sq.redirect_pending = (state == HOLD);
  assign sq.halted           = (state == HALT);
  assign sq.redirect_count   = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver applies one cycle of stimulus,
// predicts that cycle's outputs from a behavioural model and queues them; a
// monitor on the falling edge pops and compares.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fi;
    logic        fe;
    logic        pend;
    logic        hlt;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // behavioural model
  logic [31:0] m_pc, m_cnt, m_tgt;
  bit          m_pending, m_halted;

  pc_sequencer_if #(.DATA_BITS(32)) sif ();

  pc_sequencer #(.DATA_BITS(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s]: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // monitor: one queued prediction per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_out",           e.tag, sif.pc_out,                   e.pc);
      chk("pc_plus4",         e.tag, sif.pc_plus4,                 e.pc4);
      chk("flush_ifid",       e.tag, {31'd0, sif.flush_ifid},       {31'd0, e.fi});
      chk("flush_idex",       e.tag, {31'd0, sif.flush_idex},       {31'd0, e.fe});
      chk("redirect_pending", e.tag, {31'd0, sif.redirect_pending}, {31'd0, e.pend});
      chk("halted",           e.tag, {31'd0, sif.halted},           {31'd0, e.hlt});
      chk("redirect_count",   e.tag, sif.redirect_count,           e.cnt);
    end
  end

  task automatic zero_inputs();
    sif.pcsel = 0; sif.branch_target = '0; sif.jmp = 0; sif.jmp_target = '0;
    sif.stall = 0; sif.imem_ready = 0; sif.halt = 0;
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1;
    zero_inputs();
    m_pc = RST_PC; m_cnt = 0; m_tgt = 0; m_pending = 0; m_halted = 0;
    e.pc = RST_PC; e.pc4 = RST_PC + 32'd4; e.fi = 0; e.fe = 0;
    e.pend = 0; e.hlt = 0; e.cnt = 0; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // one clock of stimulus; prediction comes from the sequencing rules
  task automatic step(input bit ps, input logic [31:0] bt, input bit jp, input logic [31:0] jt,
                      input bit st, input bit rd, input bit hl, input string tag);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b0;
    sif.pcsel = ps; sif.branch_target = bt; sif.jmp = jp; sif.jmp_target = jt;
    sif.stall = st; sif.imem_ready = rd; sif.halt = hl;
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.cnt = m_cnt; e.pend = m_pending;
    e.hlt = m_halted; e.fi = 0; e.fe = 0; e.tag = tag;
    if (m_halted) begin
      // frozen
    end else if (m_pending) begin
      e.fi = 1;
      if (hl) begin
        m_halted = 1; m_pending = 0;
      end else begin
        if (ps) begin m_tgt = bt; e.fe = 1; end
        if (rd) begin m_pc = m_tgt; m_cnt++; m_pending = 0; end
      end
    end else if (hl) begin
      m_halted = 1;
    end else if (ps) begin
      e.fi = 1; e.fe = 1;
      if (rd) begin m_pc = bt; m_cnt++; end
      else begin m_tgt = bt; m_pending = 1; end
    end else if (jp && !st) begin
      e.fi = 1;
      if (rd) begin m_pc = jt; m_cnt++; end
      else begin m_tgt = jt; m_pending = 1; end
    end else if (!st && rd) begin
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(e);
  endtask

  initial begin
    zero_inputs();
    do_reset("reset");
    // sequential fetch 0,4,8,12 then 0x10
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, "seq");
    // at 0x10: taken branch to 0x40
    step(1, 32'h40, 0, 0, 0, 1, 0, "branch");
    step(0, 0, 0, 0, 0, 1, 0, "after_branch");
    // branch beats stall and jump
    step(1, 32'h20, 1, 32'h80, 1, 1, 0, "br_prio");
    step(0, 0, 0, 0, 0, 1, 0, "after_br_prio");
    // jump under back-pressure for 3 cycles
    step(0, 0, 1, 32'h100, 0, 0, 0, "jmp_bp");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, "hold");
    step(0, 0, 0, 0, 0, 1, 0, "hold_release");
    step(0, 0, 0, 0, 0, 1, 0, "after_hold");
    // again, with a branch overriding the parked jump
    step(0, 0, 1, 32'h100, 0, 0, 0, "jmp_bp2");
    step(1, 32'h200, 0, 0, 0, 0, 0, "hold_branch");
    step(0, 0, 0, 0, 0, 0, 0, "hold2");
    step(0, 0, 0, 0, 0, 1, 0, "hold2_release");
    step(0, 0, 0, 0, 0, 1, 0, "after_hold2");
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom(), $urandom_range(0, 4) == 0, $urandom(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, 0, "random");
    end
    // PC wrap, then halt with noise on the other inputs
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 0, "jmp_top");
    step(0, 0, 0, 0, 0, 1, 0, "at_top");
    step(0, 0, 0, 0, 0, 1, 0, "wrapped");
    step(0, 0, 0, 0, 0, 1, 1, "halt");
    for (int i = 0; i < 10; i++)
      step($urandom_range(0, 1), $urandom(), $urandom_range(0, 1), $urandom(),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), "halted");
    do_reset("reset_after_halt");
    step(0, 0, 0, 0, 0, 1, 0, "post_halt_run");
    // halt while a redirect is parked drops it
    step(0, 0, 1, 32'h300, 0, 0, 0, "jmp_bp3");
    step(0, 0, 0, 0, 0, 0, 1, "halt_in_hold");
    step(0, 0, 1, 32'h400, 0, 1, 0, "halted2");
    // reset mid-hold drops the parked target
    do_reset("reset2");
    step(0, 0, 1, 32'h500, 0, 0, 0, "jmp_bp4");
    do_reset("reset_in_hold");
    step(0, 0, 0, 0, 0, 1, 0, "post_reset_seq");
    step(0, 0, 0, 0, 0, 1, 0, "post_reset_seq2");
    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
